// File: rtl/water_alarm_pkg.sv
// Shared state encoding and warning-code constants for the water-level alarm.
package water_alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_ALARM    = 2'd2,
        ST_SILENCED = 2'd3
    } alarm_state_e;

    localparam logic [2:0] WL_LOW    = 3'b001;
    localparam logic [2:0] WL_NORMAL = 3'b010;
    localparam logic [2:0] WL_HIGH   = 3'b100;
    localparam logic [2:0] CODE_NONE = 3'b000;

endpackage

// File: rtl/water_alarm_ctrl_if.sv
// Sensor-side inputs and alarm-side outputs of water_alarm_ctrl.
interface water_alarm_ctrl_if;

    logic       en;
    logic [2:0] warn_led;
    logic       ack;
    logic       buzzer;
    logic       blink_led;
    logic [2:0] alarm_code;

    modport master (output en, warn_led, ack, input buzzer, blink_led, alarm_code);
    modport slave  (input en, warn_led, ack, output buzzer, blink_led, alarm_code);

endinterface

// File: rtl/alarm_blink_gen.sv
// Square-wave generator for the alarm LED; restarts high on every rising edge of run.
module alarm_blink_gen #(
    parameter int unsigned BLINK_HALF = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic blink
);

    localparam logic [7:0] HALF_LAST = 8'(BLINK_HALF - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       blink_q, blink_d;
    logic       run_q, run_d;

    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        run_d   = run;
        if (!run) begin
            cnt_d   = '0;
            blink_d = 1'b0;
        end else if (!run_q) begin
            cnt_d   = '0;
            blink_d = 1'b1;
        end else if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
        end else begin
            cnt_d   = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            run_q   <= run_d;
        end
    end

    assign blink = blink_q;

endmodule

// File: rtl/water_alarm_ctrl.sv
// Debounces abnormal water-level codes into a buzzer/LED alarm with operator silencing.
module water_alarm_ctrl
    import water_alarm_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned BLINK_HALF  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    water_alarm_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE     = ST_IDLE;
    localparam logic [1:0] S_PENDING  = ST_PENDING;
    localparam logic [1:0] S_ALARM    = ST_ALARM;
    localparam logic [1:0] S_SILENCED = ST_SILENCED;
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] held_q, held_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       buzzer_q, buzzer_d;
    logic       silenced_q, silenced_d;
    logic [2:0] alarm_code_q, alarm_code_d;
    logic       abnormal, match, blink_run, blink;

    always_comb begin
        abnormal   = bus.en && (bus.warn_led != WL_NORMAL);
        match      = bus.en && (bus.warn_led == held_q);
        state_d    = state_q;
        held_d     = held_q;
        hold_cnt_d = hold_cnt_q;

        // Losing the held code (or enable) wins over everything, including ack.
        if (state_q != S_IDLE && !match) begin
            state_d    = S_IDLE;
            held_d     = CODE_NONE;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: if (abnormal) begin
                    state_d    = S_PENDING;
                    held_d     = bus.warn_led;
                    hold_cnt_d = '0;
                end
                S_PENDING: begin
                    if (hold_cnt_q == HOLD_LAST) state_d = S_ALARM;
                    else                         hold_cnt_d = hold_cnt_q + 8'd1;
                end
                S_ALARM: if (bus.ack) state_d = S_SILENCED;
                default: ;
            endcase
        end

        buzzer_d     = (state_d == S_ALARM);
        silenced_d   = (state_d == S_SILENCED);
        alarm_code_d = (buzzer_d || silenced_d) ? held_d : CODE_NONE;
        blink_run    = buzzer_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            held_q       <= CODE_NONE;
            hold_cnt_q   <= '0;
            buzzer_q     <= 1'b0;
            silenced_q   <= 1'b0;
            alarm_code_q <= CODE_NONE;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            hold_cnt_q   <= hold_cnt_d;
            buzzer_q     <= buzzer_d;
            silenced_q   <= silenced_d;
            alarm_code_q <= alarm_code_d;
        end
    end

    alarm_blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (blink_run),
        .blink (blink)
    );

    assign bus.buzzer     = buzzer_q;
    assign bus.blink_led  = blink | silenced_q;
    assign bus.alarm_code = alarm_code_q;

endmodule
